// File: rtl/seq_pattern_tx.sv
// Serial 1010 pattern source: serializes handshaked words MSB-first with an idle gap,
// and carries a golden non-overlapping Mealy 1010 detector plus saturating match counter.
module seq_pattern_tx #(
  parameter int W     = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_done,
  output logic             exp_z,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0]    BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    T_A,
    T_B,
    T_C,
    T_D
  } trk_state_t;

  tx_state_t  state;
  trk_state_t trk;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          last_bit;
  logic          accept;

  assign last_bit   = (state == S_SHIFT) && (bit_cnt == '0);
  // With no gap the last bit cycle doubles as the accept slot, giving back-to-back words.
  assign in_ready   = (state == S_IDLE) || (last_bit && (GAP == 0));
  assign accept     = in_valid && in_ready;
  assign x_valid    = (state == S_SHIFT);
  assign x_out      = x_valid && shreg[W-1];
  assign frame_done = last_bit;
  assign exp_z      = (trk == T_D) && !x_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg   <= in_data;
            bit_cnt <= BIT_LAST;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end else if (GAP > 0) begin
            shreg   <= shreg << 1;
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end else if (accept) begin
            shreg   <= in_data;
            bit_cnt <= BIT_LAST;
          end else begin
            shreg   <= shreg << 1;
            state   <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tracker sees every x_out value, idle and gap zeros included, like the real detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk <= T_A;
    end else begin
      case (trk)
        T_A:     trk <= x_out ? T_B : T_A;
        T_B:     trk <= x_out ? T_B : T_C;
        T_C:     trk <= x_out ? T_D : T_A;
        T_D:     trk <= x_out ? T_B : T_A;
        default: trk <= T_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (exp_z && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a GAP=2 instance and a GAP=0 / 2-bit-counter instance,
// checked every cycle against a scoreboard of expected bit-stream entries and a history model.
module tb_seq_pattern_tx;

  localparam int W = 8;

  typedef struct packed {
    logic x;
    logic xv;
    logic fd;
    logic rdy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_v   [2];
  logic [7:0] in_d   [2];
  logic       in_clr [2];

  logic       rdy_a, rdy_b, x_a, x_b, xv_a, xv_b, fd_a, fd_b, z_a, z_b;
  logic [7:0] mc_a;
  logic [1:0] mc_b;

  logic [1:0]  o_x, o_xv, o_fd, o_z, o_rdy;
  logic [31:0] o_mc [2];

  assign o_x   = {x_b, x_a};
  assign o_xv  = {xv_b, xv_a};
  assign o_fd  = {fd_b, fd_a};
  assign o_z   = {z_b, z_a};
  assign o_rdy = {rdy_b, rdy_a};
  assign o_mc[0] = 32'(mc_a);
  assign o_mc[1] = 32'(mc_b);

  seq_pattern_tx #(.W(8), .GAP(2), .CNT_W(8)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_v[0]),
    .in_data    (in_d[0]),
    .in_ready   (rdy_a),
    .x_out      (x_a),
    .x_valid    (xv_a),
    .frame_done (fd_a),
    .exp_z      (z_a),
    .match_cnt  (mc_a),
    .cnt_clr    (in_clr[0])
  );

  seq_pattern_tx #(.W(8), .GAP(0), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_v[1]),
    .in_data    (in_d[1]),
    .in_ready   (rdy_b),
    .x_out      (x_b),
    .x_valid    (xv_b),
    .frame_done (fd_b),
    .exp_z      (z_b),
    .match_cnt  (mc_b),
    .cnt_clr    (in_clr[1])
  );

  exp_t       q [2][$];
  logic [3:0] hist [2];
  int         since [2];
  int         cnt [2];
  int         gap_of [2] = '{2, 0};
  int         cmax [2]   = '{255, 3};
  int         checks = 0;
  int         errors = 0;
  bit         clr_on_z = 1'b0;
  bit         clr_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A match is the last four bits reading 1010 with no overlap into the previous match.
  task automatic model_z(input int id, input logic x, output logic m);
    hist[id]  = {hist[id][2:0], x};
    since[id] = since[id] + 1;
    m = (hist[id] == 4'b1010) && (since[id] >= 4);
    if (m) since[id] = 0;
  endtask

  task automatic step();
    for (int id = 0; id < 2; id++) begin
      exp_t  e;
      exp_t  n;
      logic  z;
      string nm;
      nm = (id == 0) ? "a" : "b";
      if (q[id].size() > 0) e = q[id].pop_front();
      else e = '{x: 1'b0, xv: 1'b0, fd: 1'b0, rdy: 1'b1};
      model_z(id, e.x, z);
      chk($sformatf("%s.x_out", nm), 32'(o_x[id]), 32'(e.x));
      chk($sformatf("%s.x_valid", nm), 32'(o_xv[id]), 32'(e.xv));
      chk($sformatf("%s.frame_done", nm), 32'(o_fd[id]), 32'(e.fd));
      chk($sformatf("%s.in_ready", nm), 32'(o_rdy[id]), 32'(e.rdy));
      chk($sformatf("%s.exp_z", nm), 32'(o_z[id]), 32'(z));
      chk($sformatf("%s.match_cnt", nm), o_mc[id], 32'(cnt[id]));
      $display("t=%0t %s x=%b xv=%b fd=%b rdy=%b z=%b cnt=%0d", $time, nm,
               o_x[id], o_xv[id], o_fd[id], o_rdy[id], o_z[id], o_mc[id]);
      if (id == 1 && clr_done) begin
        chk("b.cnt_after_clr_on_z", o_mc[1], 32'd0);
        clr_done = 1'b0;
      end
      if (id == 1 && clr_on_z && z) begin
        in_clr[1] = 1'b1;
        clr_on_z  = 1'b0;
        clr_done  = 1'b1;
      end
      if (in_clr[id]) cnt[id] = 0;
      else if (z && cnt[id] < cmax[id]) cnt[id] = cnt[id] + 1;
      if (in_v[id] && e.rdy) begin
        for (int i = W - 1; i >= 0; i--) begin
          n.x   = in_d[id][i];
          n.xv  = 1'b1;
          n.fd  = (i == 0);
          n.rdy = (i == 0) && (gap_of[id] == 0);
          q[id].push_back(n);
        end
        for (int g = 0; g < gap_of[id]; g++) begin
          n = '{x: 1'b0, xv: 1'b0, fd: 1'b0, rdy: 1'b0};
          q[id].push_back(n);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_clr[0] = 1'b0;
    in_clr[1] = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int id = 0; id < 2; id++) begin
      chk("rst.x_out", 32'(o_x[id]), 32'd0);
      chk("rst.x_valid", 32'(o_xv[id]), 32'd0);
      chk("rst.frame_done", 32'(o_fd[id]), 32'd0);
      chk("rst.exp_z", 32'(o_z[id]), 32'd0);
      chk("rst.in_ready", 32'(o_rdy[id]), 32'd1);
      chk("rst.match_cnt", o_mc[id], 32'd0);
      q[id].delete();
      hist[id]  = 4'b0000;
      since[id] = 0;
      cnt[id]   = 0;
    end
    $display("t=%0t reset applied", $time);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    in_v   = '{1'b0, 1'b0};
    in_d   = '{8'h00, 8'h00};
    in_clr = '{1'b0, 1'b0};
    @(negedge clk);
    do_reset();
    repeat (2) step();

    // GAP=2: A0 gives one match on bit 4
    in_v[0] = 1'b1; in_d[0] = 8'hA0; step();
    in_v[0] = 1'b0; in_d[0] = 8'hFF; repeat (12) step();
    chk("a.cnt_A0", o_mc[0], 32'd1);

    // AA matches on bits 4 and 8 only
    in_clr[0] = 1'b1; step();
    in_v[0] = 1'b1; in_d[0] = 8'hAA; step();
    in_v[0] = 1'b0; repeat (12) step();
    chk("a.cnt_AA", o_mc[0], 32'd2);

    // 05 completes its match on the first gap cycle
    in_clr[0] = 1'b1; step();
    in_v[0] = 1'b1; in_d[0] = 8'h05; step();
    in_v[0] = 1'b0; repeat (12) step();
    chk("a.cnt_05_gap", o_mc[0], 32'd1);

    // GAP=0 back-to-back 05 then 00, data changed mid-word
    in_v[1] = 1'b1; in_d[1] = 8'h05; step();
    in_d[1] = 8'h00; repeat (8) step();
    in_v[1] = 1'b0; repeat (10) step();
    chk("b.cnt_gap0", o_mc[1], 32'd1);

    // saturation of the 2-bit counter
    in_clr[1] = 1'b1; step();
    in_v[1] = 1'b1; in_d[1] = 8'hAA; repeat (25) step();
    in_v[1] = 1'b0; repeat (12) step();
    chk("b.cnt_sat", o_mc[1], 32'd3);

    // clear coincident with a match, then one more match in the same word
    in_v[1] = 1'b1; clr_on_z = 1'b1; step();
    in_v[1] = 1'b0; repeat (12) step();
    chk("b.cnt_clr_then_match", o_mc[1], 32'd1);

    // reset mid-word, then a clean word
    in_v[0] = 1'b1; in_d[0] = 8'hAA; step();
    in_v[0] = 1'b0; repeat (3) step();
    do_reset();
    in_v[0] = 1'b1; in_d[0] = 8'h0A; step();
    in_v[0] = 1'b0; repeat (12) step();
    chk("a.cnt_after_rst", o_mc[0], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives the single-bit `x` input of the team's Mealy 1010 sequence detectors. It accepts parallel words over a valid/ready handshake and serializes them MSB-first at one bit per clock, with a programmable idle gap between words. It carries a built-in golden model of the non-overlapping 1010 detector (`exp_z`, `match_cnt`), so benches can compare the detector under test against it cycle by cycle.

## Interface
Parameters:
- `W`, default 8: word width in bits (at least 2).
- `GAP`, default 2: number of idle cycles inserted after each word (0 or more).
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  a word is offered on `in_data`.
- `in_data`  in  W  word to transmit, MSB first.
- `in_ready`  out  1  the block can accept a word this cycle.
- `x_out`  out  1  serial bit stream; connects to the detector `x` input.
- `x_valid`  out  1  `x_out` carries a data bit (not idle or gap).
- `frame_done`  out  1  one-cycle pulse on the cycle the last bit of a word is presented.
- `exp_z`  out  1  golden Mealy detector output for the current `x_out`.
- `match_cnt`  out  CNT_W  count of `exp_z` pulses; saturates at the maximum value.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.

## Operation
Transmit FSM states:
- IDLE
  - `in_ready` = 1, `x_out` = 0, `x_valid` = 0.
  - On `in_valid & in_ready`: load the shift register with `in_data`, set the bit counter to W-1, go to SHIFT.
- SHIFT
  - `x_out` = shift register MSB, `x_valid` = 1.
  - Each cycle: shift left by one, decrement the bit counter.
  - When the bit counter is 0 (last bit): `frame_done` = 1.
  - After the last bit: if GAP > 0, go to GAP with the gap counter set to GAP-1.
  - After the last bit with GAP = 0: `in_ready` = 1 in the same cycle. An accepted word reloads immediately and stays in SHIFT with no bubble; otherwise go to IDLE.
- GAP
  - `x_out` = 0, `x_valid` = 0, `in_ready` = 0.
  - Decrement the gap counter; when it reaches 0, go to IDLE.

`in_ready` is combinational from state and bit counter only. It never depends on `in_valid`.

Golden tracker (states A, B=seen "1", C=seen "10", D=seen "101"):
- Advances on every clock using `x_out`, including idle and gap zeros, exactly as the downstream detector does.
- Transitions:
  - A: 0→A, 1→B
  - B: 0→C, 1→B
  - C: 0→A, 1→D
  - D: 0→A, 1→B
- `exp_z` = (tracker == D) & (`x_out` == 0). Combinational, same cycle as the completing bit.
- Detection is non-overlapping: after a match the tracker returns to A.

Match counter:
- `cnt_clr` has priority: `match_cnt` ← 0.
- Otherwise, if `exp_z` and `match_cnt` < 2^CNT_W-1: `match_cnt` increments by 1.
- At all ones, `match_cnt` holds.

## Timing
- Reset values: FSM IDLE, shift register 0, tracker A, `match_cnt` 0.
  - Outputs during reset: `x_out` 0, `x_valid` 0, `frame_done` 0, `exp_z` 0, `in_ready` 1.
- Latency: handshake on edge N → first bit on `x_out` from edge N through edge N+1 → last bit at edge N+W-1 with `frame_done` high.
- Word period: W+GAP+1 cycles when GAP > 0 (includes one IDLE cycle); exactly W when GAP = 0 and `in_valid` is held.
- A pattern spanning a word boundary or a word/gap boundary is detected, because the tracker never resets between words.
- `in_data` is sampled only at the handshake. Changes to `in_data` at other times have no effect.
- Asserting `rst_n` mid-word aborts the word:
  - All state returns to reset values immediately.
  - The partial word is not resumed.
  - `match_cnt` is cleared.
- `cnt_clr` in the same cycle as `exp_z`: `match_cnt` = 0 on the next cycle.

## Test plan
- GAP=2, W=8, send 8'hA0 → `x_out` 1,0,1,0,0,0,0,0; `exp_z` high only on the 4th bit; `frame_done` on the 8th bit; `match_cnt` = 1; `in_ready` returns 3 cycles after `frame_done`.
- Send 8'hAA → matches on bits 4 and 8 only (non-overlapping, not 3); `match_cnt` = 2.
- GAP=0, hold `in_valid` with 8'h05 then 8'h00 → no bubble between words; `exp_z` on the first bit of the second word; `match_cnt` = 1.
- GAP=2, single 8'h05 → `exp_z` fires on the first gap cycle (`x_valid`=0, `x_out`=0); `match_cnt` = 1.
- CNT_W=2, stream 8'hAA repeatedly → `match_cnt` saturates at 3; `cnt_clr` in a cycle with `exp_z`=1 → `match_cnt` = 0 next cycle.
- Drop `rst_n` after bit 3 of 8'hAA → all outputs at reset values; the next word 8'h0A starts cleanly with the tracker in A; `match_cnt` = 1.
